kernel_mem_bank: RTL and testbench
==================================

# kernel_mem_bank

Multi-bank kernel store that holds kernel data for several convolution groups at once, so a new kernel set can load while the datapath reads another. Each bank is a circular buffer with its own write pointer and release-point credit. A single read port selects bank and start address, then streams entries on pop with a registered valid. It sits between the kernel load path and the convolution array.

## Interface
- GROUP_NB, 4, kernels per memory word
- KER_WIDTH, 16, bits per kernel value
- MEM_AWIDTH, 16, per-bank address width
- MEM_DEPTH, 1<<MEM_AWIDTH, entries per bank; any value 2..2^MEM_AWIDTH (non-power-of-2 allowed)
- BANK_NB, 2, number of banks (>=2)
- BANK_AWIDTH, 1, bank select width; 2^BANK_AWIDTH >= BANK_NB

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_cfg_bank  in  BANK_AWIDTH  bank targeted by wr_cfg_set
- wr_cfg_end  in  MEM_AWIDTH  new release point for that bank
- wr_cfg_set  in  1  load wr_cfg_end into the selected bank
- wr_bank  in  BANK_AWIDTH  bank targeted by the write beat
- wr_data  in  GROUP_NB*KER_WIDTH  write word
- wr_data_val  in  1  write beat offered
- wr_data_rdy  out  1  selected bank accepts (= wr_bank_rdy[wr_bank])
- wr_bank_rdy  out  BANK_NB  per-bank accept status
- rd_bank  in  BANK_AWIDTH  bank for read pointer load
- rd_addr  in  MEM_AWIDTH  start address for read pointer load
- rd_addr_set  in  1  load rd_bank/rd_addr into read pointer
- rd_data  out  GROUP_NB*KER_WIDTH  read word (held until next read completes)
- rd_data_val  out  1  one-cycle pulse: rd_data updated
- rd_data_pop  in  1  read entry at read pointer and advance

## Operation
- Per bank b: wr_ptr[b], wr_ptr_wrap[b], wr_end[b], wr_end_wrap[b].
- wr_bank_rdy[b] = ~((wr_ptr_wrap[b] != wr_end_wrap[b]) && (wr_ptr[b] == wr_end[b])).
- Write beat = wr_data_val & wr_data_rdy: mem[wr_bank][wr_ptr] <= wr_data; wr_ptr increments; at MEM_DEPTH-1 wraps to 0 and toggles wr_ptr_wrap.
- wr_cfg_set: wr_end[cfg bank] <= wr_cfg_end; if old wr_end >= wr_cfg_end, toggle wr_end_wrap. wr_end marks the oldest entry still needed; the writer may lap up to it, not past.
- Out-of-range bank index (>= BANK_NB) on write, cfg or read: ignored; wr_data_rdy = 0 for it.
- Read pointer: rd_addr_set loads rd_bank_q/rd_ptr; else pop advances rd_ptr, wrapping MEM_DEPTH-1 -> 0 within the same bank.
- Pop reads mem[rd_bank_q][rd_ptr] using the pre-update pointer.
- Simultaneous rd_addr_set and pop: pop reads the old pointer; the set wins for the pointer update.
- Simultaneous write and cfg on the same bank: both apply; rdy uses pre-update registers.
- The read side performs no occupancy check; software guarantees reads only cover written entries.
- Reset clears all pointers, wrap bits, wr_end, rd_bank_q, rd_data, rd_data_val; memory contents are not reset.

## Timing
- Reset values: wr_data_rdy=1, wr_bank_rdy=all ones, rd_data=0, rd_data_val=0.
- Write: one beat per cycle per port; rdy updates the cycle after the accepting/cfg edge.
- Read latency: pop at edge N -> rd_data/rd_data_val valid after edge N+1 (1 cycle); back-to-back pops stream one word per cycle.
- Write and read same bank/address same cycle: read returns old contents.
- Reset asserted mid-stream: outputs go to reset values immediately (asynchronous) and in-flight pops are dropped.

## Configuration
- KERNEL_MEM_BANK_OREG_EN defined: extra output register after the RAM read; read latency 2 cycles, rd_data_val delayed to match, full pop throughput kept, new register also reset to 0.
- Not defined: 1-cycle read latency as above.

## Test plan
- Reset, BANK_NB=2, MEM_DEPTH=12: write 12 words to bank 0 -> rdy drops after 12th beat; wr_bank_rdy=2'b10.
- Continue: cfg bank0 end=5 (no toggle) -> 5 more beats (addr 0..4) accepted, blocked at ptr 5; then cfg end=2 (toggle) -> 9 beats (addr 5..11,0,1) accepted, blocked at ptr 2.
- Interleave writes to bank 0 and 1 with different data -> each bank's contents independent; bank 1 full does not stall bank 0.
- rd_bank=1, rd_addr=10, set, then 4 pops -> data of addr 10,11,0,1 of bank 1; rd_data_val pulses 1 cycle after each pop (2 with OREG).
- rd_addr_set with pop same cycle (ptr=3, addr=7) -> returns addr 3, next pop returns addr 7.
- Assert rst during streaming pops -> rd_data_val=0, rd_data=0, wr_data_rdy=1 immediately; no stale valid after release.

Source files
------------

// File: rtl/kernel_mem_bank.sv
// Multi-bank circular kernel store: per-bank write pointer with release-point credit, one shared read stream.
// Optional KERNEL_MEM_BANK_OREG_EN adds an output register after the RAM read (2-cycle read latency).
module kernel_mem_bank #(
  parameter int GROUP_NB    = 4,
  parameter int KER_WIDTH   = 16,
  parameter int MEM_AWIDTH  = 16,
  parameter int MEM_DEPTH   = 1 << MEM_AWIDTH,
  parameter int BANK_NB     = 2,
  parameter int BANK_AWIDTH = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BANK_AWIDTH-1:0]          wr_cfg_bank,
  input  logic [MEM_AWIDTH-1:0]           wr_cfg_end,
  input  logic                            wr_cfg_set,
  input  logic [BANK_AWIDTH-1:0]          wr_bank,
  input  logic [GROUP_NB*KER_WIDTH-1:0]   wr_data,
  input  logic                            wr_data_val,
  output logic                            wr_data_rdy,
  output logic [BANK_NB-1:0]              wr_bank_rdy,
  input  logic [BANK_AWIDTH-1:0]          rd_bank,
  input  logic [MEM_AWIDTH-1:0]           rd_addr,
  input  logic                            rd_addr_set,
  output logic [GROUP_NB*KER_WIDTH-1:0]   rd_data,
  output logic                            rd_data_val,
  input  logic                            rd_data_pop
);

  localparam int DW = GROUP_NB * KER_WIDTH;
  localparam logic [MEM_AWIDTH-1:0] LAST_ADDR = MEM_AWIDTH'(MEM_DEPTH - 1);

  logic [BANK_NB-1:0] wr_sel;
  logic [BANK_NB-1:0] cfg_sel;
  logic [BANK_NB-1:0] rd_sel;
  logic               wr_fire;
  logic [DW-1:0]      bank_rd_data [BANK_NB];

  logic [BANK_AWIDTH-1:0] rd_bank_q, rd_bank_d;
  logic [MEM_AWIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BANK_AWIDTH-1:0] rd_src_q, rd_src_d;
  logic                   rd_seen_q, rd_seen_d;
  logic                   rd_val_q, rd_val_d;
  logic                   rd_set_ok;
  logic [DW-1:0]          ram_word;

  assign wr_data_rdy = |(wr_bank_rdy & wr_sel);
  assign wr_fire     = wr_data_val & wr_data_rdy;
  assign rd_set_ok   = rd_addr_set && (int'(rd_bank) < BANK_NB);

  genvar gi;
  generate
    for (gi = 0; gi < BANK_NB; gi++) begin : g_bank
      logic [MEM_AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
      logic [MEM_AWIDTH-1:0] wr_end_q, wr_end_d;
      logic                  wr_ptr_wrap_q, wr_ptr_wrap_d;
      logic                  wr_end_wrap_q, wr_end_wrap_d;
      logic [DW-1:0]         mem [MEM_DEPTH];
      logic [DW-1:0]         rd_word_q;

      assign wr_sel[gi]  = (int'(wr_bank) == gi);
      assign cfg_sel[gi] = (int'(wr_cfg_bank) == gi);
      assign rd_sel[gi]  = (int'(rd_bank_q) == gi);
      // Full only when the writer has lapped exactly onto the release point.
      assign wr_bank_rdy[gi] = ~((wr_ptr_wrap_q != wr_end_wrap_q) && (wr_ptr_q == wr_end_q));
      assign bank_rd_data[gi] = rd_word_q;

      always_comb begin
        wr_ptr_d      = wr_ptr_q;
        wr_ptr_wrap_d = wr_ptr_wrap_q;
        wr_end_d      = wr_end_q;
        wr_end_wrap_d = wr_end_wrap_q;
        if (wr_fire && wr_sel[gi]) begin
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d      = '0;
            wr_ptr_wrap_d = ~wr_ptr_wrap_q;
          end else begin
            wr_ptr_d = wr_ptr_q + MEM_AWIDTH'(1);
          end
        end
        if (wr_cfg_set && cfg_sel[gi]) begin
          wr_end_d = wr_cfg_end;
          if (wr_end_q >= wr_cfg_end) begin
            wr_end_wrap_d = ~wr_end_wrap_q;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr_q      <= '0;
          wr_ptr_wrap_q <= 1'b0;
          wr_end_q      <= '0;
          wr_end_wrap_q <= 1'b0;
        end else begin
          wr_ptr_q      <= wr_ptr_d;
          wr_ptr_wrap_q <= wr_ptr_wrap_d;
          wr_end_q      <= wr_end_d;
          wr_end_wrap_q <= wr_end_wrap_d;
        end
      end

      // Unreset RAM with registered read; a same-address write returns old contents.
      always_ff @(posedge clk) begin
        if (wr_fire && wr_sel[gi]) begin
          mem[wr_ptr_q] <= wr_data;
        end
        if (rd_data_pop && rd_sel[gi]) begin
          rd_word_q <= mem[rd_ptr_q];
        end
      end
    end
  endgenerate

  always_comb begin
    rd_bank_d = rd_bank_q;
    rd_ptr_d  = rd_ptr_q;
    if (rd_set_ok) begin
      rd_bank_d = rd_bank;
      rd_ptr_d  = rd_addr;
    end else if (rd_data_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + MEM_AWIDTH'(1);
    end
    rd_src_d  = rd_data_pop ? rd_bank_q : rd_src_q;
    rd_seen_d = rd_seen_q | rd_data_pop;
    rd_val_d  = rd_data_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_q <= '0;
      rd_ptr_q  <= '0;
      rd_src_q  <= '0;
      rd_seen_q <= 1'b0;
      rd_val_q  <= 1'b0;
    end else begin
      rd_bank_q <= rd_bank_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_src_q  <= rd_src_d;
      rd_seen_q <= rd_seen_d;
      rd_val_q  <= rd_val_d;
    end
  end

  // Until the first pop after reset the bank read registers hold garbage, so force zero.
  always_comb begin
    ram_word = '0;
    for (int b = 0; b < BANK_NB; b++) begin
      if (rd_seen_q && (int'(rd_src_q) == b)) begin
        ram_word = bank_rd_data[b];
      end
    end
  end

`ifdef KERNEL_MEM_BANK_OREG_EN
  logic [DW-1:0] rd_out_q, rd_out_d;
  logic          rd_out_val_q, rd_out_val_d;

  always_comb begin
    rd_out_d     = rd_val_q ? ram_word : rd_out_q;
    rd_out_val_d = rd_val_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_out_q     <= '0;
      rd_out_val_q <= 1'b0;
    end else begin
      rd_out_q     <= rd_out_d;
      rd_out_val_q <= rd_out_val_d;
    end
  end

  assign rd_data     = rd_out_q;
  assign rd_data_val = rd_out_val_q;
`else
  assign rd_data     = ram_word;
  assign rd_data_val = rd_val_q;
`endif

endmodule

// File: tb/tb_kernel_mem_bank.sv
// Bench for kernel_mem_bank: directed scenarios plus random traffic against an absolute-count credit model.
module tb_kernel_mem_bank;
  localparam int GROUP_NB    = 4;
  localparam int KER_WIDTH   = 16;
  localparam int MEM_AWIDTH  = 4;
  localparam int MEM_DEPTH   = 12;
  localparam int BANK_NB     = 2;
  localparam int BANK_AWIDTH = 1;
  localparam int DW          = GROUP_NB * KER_WIDTH;
`ifdef KERNEL_MEM_BANK_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                   clk;
  logic                   rst;
  logic [BANK_AWIDTH-1:0] wr_cfg_bank;
  logic [MEM_AWIDTH-1:0]  wr_cfg_end;
  logic                   wr_cfg_set;
  logic [BANK_AWIDTH-1:0] wr_bank;
  logic [DW-1:0]          wr_data;
  logic                   wr_data_val;
  logic                   wr_data_rdy;
  logic [BANK_NB-1:0]     wr_bank_rdy;
  logic [BANK_AWIDTH-1:0] rd_bank;
  logic [MEM_AWIDTH-1:0]  rd_addr;
  logic                   rd_addr_set;
  logic [DW-1:0]          rd_data;
  logic                   rd_data_val;
  logic                   rd_data_pop;

  kernel_mem_bank #(
    .GROUP_NB(GROUP_NB), .KER_WIDTH(KER_WIDTH), .MEM_AWIDTH(MEM_AWIDTH),
    .MEM_DEPTH(MEM_DEPTH), .BANK_NB(BANK_NB), .BANK_AWIDTH(BANK_AWIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_cfg_bank(wr_cfg_bank), .wr_cfg_end(wr_cfg_end), .wr_cfg_set(wr_cfg_set),
    .wr_bank(wr_bank), .wr_data(wr_data), .wr_data_val(wr_data_val),
    .wr_data_rdy(wr_data_rdy), .wr_bank_rdy(wr_bank_rdy),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_addr_set(rd_addr_set),
    .rd_data(rd_data), .rd_data_val(rd_data_val), .rd_data_pop(rd_data_pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: total words written and absolute release position per bank; free space = DEPTH - (written - released).
  logic [DW-1:0] m_mem [BANK_NB][MEM_DEPTH];
  int            m_wcnt [BANK_NB];
  int            m_endabs [BANK_NB];
  int            m_rb, m_rp;
  logic          m_pv [LAT];
  logic [DW-1:0] m_pd [LAT];
  logic          m_outv;
  logic [DW-1:0] m_out;
  int            checks, errors;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_rdy(input int b);
    return (m_wcnt[b] - m_endabs[b]) < MEM_DEPTH;
  endfunction

  task automatic m_reset();
    for (int b = 0; b < BANK_NB; b++) begin
      m_wcnt[b]   = 0;
      m_endabs[b] = 0;
    end
    m_rb = 0;
    m_rp = 0;
    for (int i = 0; i < LAT; i++) begin
      m_pv[i] = 1'b0;
      m_pd[i] = '0;
    end
    m_outv = 1'b0;
    m_out  = '0;
  endtask

  task automatic clear_inputs();
    wr_cfg_set  = 1'b0;
    wr_data_val = 1'b0;
    rd_addr_set = 1'b0;
    rd_data_pop = 1'b0;
  endtask

  // Apply the current inputs for one clock edge, advance the model, then check all outputs.
  task automatic cycle(input string tag);
    logic          pv;
    logic          wok;
    logic [DW-1:0] pd;
    logic [BANK_NB-1:0] exp_rdy;
    int            old_end, nw;
    pv = rd_data_pop;
    pd = pv ? m_mem[m_rb][m_rp] : '0;
    if (rd_addr_set) begin
      m_rb = int'(rd_bank);
      m_rp = int'(rd_addr);
    end else if (pv) begin
      m_rp = (m_rp + 1) % MEM_DEPTH;
    end
    wok = wr_data_val && m_rdy(int'(wr_bank));
    if (wok) begin
      m_mem[wr_bank][m_wcnt[wr_bank] % MEM_DEPTH] = wr_data;
      m_wcnt[wr_bank]++;
    end
    if (wr_cfg_set) begin
      old_end = m_endabs[wr_cfg_bank] % MEM_DEPTH;
      nw      = int'(wr_cfg_end);
      m_endabs[wr_cfg_bank] += (nw > old_end) ? (nw - old_end) : (MEM_DEPTH - old_end + nw);
    end
    for (int i = LAT - 1; i > 0; i--) begin
      m_pv[i] = m_pv[i-1];
      m_pd[i] = m_pd[i-1];
    end
    m_pv[0] = pv;
    m_pd[0] = pd;
    m_outv  = m_pv[LAT-1];
    if (m_outv) m_out = m_pd[LAT-1];
    @(posedge clk);
    #1;
    for (int b = 0; b < BANK_NB; b++) exp_rdy[b] = m_rdy(b);
    chk({tag, ".rd_val"}, DW'(rd_data_val), DW'(m_outv));
    chk({tag, ".rd_data"}, rd_data, m_out);
    chk({tag, ".bank_rdy"}, DW'(wr_bank_rdy), DW'(exp_rdy));
    chk({tag, ".wr_rdy"}, DW'(wr_data_rdy), DW'(m_rdy(int'(wr_bank))));
  endtask

  task automatic wr_beat(input int b, input string tag);
    wr_bank     = BANK_AWIDTH'(b);
    wr_data     = {$urandom, $urandom};
    wr_data_val = 1'b1;
    cycle(tag);
    wr_data_val = 1'b0;
  endtask

  task automatic cfg(input int b, input int e, input string tag);
    wr_cfg_bank = BANK_AWIDTH'(b);
    wr_cfg_end  = MEM_AWIDTH'(e);
    wr_cfg_set  = 1'b1;
    cycle(tag);
    wr_cfg_set = 1'b0;
  endtask

  initial begin
    int avail, a, b;
    checks = 0;
    errors = 0;
    wr_cfg_bank = '0; wr_cfg_end = '0; wr_bank = '0; wr_data = '0;
    rd_bank = '0; rd_addr = '0;
    clear_inputs();
    m_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.wr_rdy", DW'(wr_data_rdy), DW'(1'b1));
    chk("reset.bank_rdy", DW'(wr_bank_rdy), DW'(2'b11));
    chk("reset.rd_data", rd_data, '0);
    chk("reset.rd_val", DW'(rd_data_val), DW'(1'b0));
    rst = 1'b0;

    // Fill bank 0, then release in two steps (no toggle, then toggle).
    for (int i = 0; i < 12; i++) wr_beat(0, "fill0");
    chk("full0.bank_rdy", DW'(wr_bank_rdy), DW'(2'b10));
    chk("full0.wr_rdy", DW'(wr_data_rdy), DW'(1'b0));
    wr_beat(0, "blocked0");
    cfg(0, 5, "cfg5");
    for (int i = 0; i < 6; i++) wr_beat(0, "after_cfg5");
    chk("blocked5.bank_rdy", DW'(wr_bank_rdy), DW'(2'b10));
    cfg(0, 2, "cfg2");
    for (int i = 0; i < 10; i++) wr_beat(0, "after_cfg2");
    chk("blocked2.bank_rdy", DW'(wr_bank_rdy), DW'(2'b10));

    // Full-lap release on bank 0, then interleave both banks.
    cfg(0, 2, "cfg_lap");
    for (int i = 0; i < 26; i++) wr_beat(i % 2, "interleave");
    for (int i = 0; i < 3; i++) wr_beat(1, "blocked1");
    cfg(0, 6, "cfg6");
    for (int i = 0; i < 4; i++) wr_beat(0, "bank0_while_bank1_full");
    chk("mixed.bank_rdy", DW'(wr_bank_rdy), DW'(2'b00));

    // Read bank 1 from address 10 across the wrap.
    rd_bank = 1'b1; rd_addr = 4'd10; rd_addr_set = 1'b1;
    cycle("rdset10");
    rd_addr_set = 1'b0;
    rd_data_pop = 1'b1;
    for (int i = 0; i < 4; i++) cycle("pop_wrap");
    rd_data_pop = 1'b0;
    repeat (LAT) cycle("drain");

    // Set and pop in the same cycle.
    rd_addr = 4'd3; rd_addr_set = 1'b1;
    cycle("rdset3");
    rd_addr = 4'd7; rd_data_pop = 1'b1;
    cycle("set_and_pop");
    rd_addr_set = 1'b0;
    cycle("pop_after_set");
    rd_data_pop = 1'b0;
    repeat (LAT + 1) cycle("drain2");

    // Random traffic; release points only cover words already written.
    for (int n = 0; n < 400; n++) begin
      wr_bank     = BANK_AWIDTH'($urandom_range(0, BANK_NB - 1));
      wr_data     = {$urandom, $urandom};
      wr_data_val = ($urandom_range(0, 3) != 0);
      rd_data_pop = ($urandom_range(0, 2) != 0);
      rd_addr_set = ($urandom_range(0, 7) == 0);
      rd_bank     = BANK_AWIDTH'($urandom_range(0, BANK_NB - 1));
      rd_addr     = MEM_AWIDTH'($urandom_range(0, MEM_DEPTH - 1));
      wr_cfg_set  = 1'b0;
      b = $urandom_range(0, BANK_NB - 1);
      avail = m_wcnt[b] - m_endabs[b];
      if (($urandom_range(0, 5) == 0) && avail > 0) begin
        a = $urandom_range(1, (avail < MEM_DEPTH) ? avail : MEM_DEPTH);
        wr_cfg_bank = BANK_AWIDTH'(b);
        wr_cfg_end  = MEM_AWIDTH'((m_endabs[b] + a) % MEM_DEPTH);
        wr_cfg_set  = 1'b1;
      end
      cycle("random");
    end
    clear_inputs();
    repeat (LAT) cycle("drain3");

    // Reset in the middle of a pop stream.
    rd_bank = 1'b0; rd_addr = 4'd0; rd_addr_set = 1'b1;
    cycle("rdset_pre_rst");
    rd_addr_set = 1'b0;
    rd_data_pop = 1'b1;
    repeat (3) cycle("stream");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.rd_val", DW'(rd_data_val), DW'(1'b0));
    chk("rst_mid.rd_data", rd_data, '0);
    chk("rst_mid.wr_rdy", DW'(wr_data_rdy), DW'(1'b1));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold.rd_val", DW'(rd_data_val), DW'(1'b0));
    rd_data_pop = 1'b0;
    rst = 1'b0;
    m_reset();
    repeat (3) cycle("post_rst_idle");

    // Memory contents survive reset.
    rd_addr = 4'd5; rd_addr_set = 1'b1;
    cycle("rdset_post_rst");
    rd_addr_set = 1'b0;
    rd_data_pop = 1'b1;
    cycle("pop_post_rst");
    rd_data_pop = 1'b0;
    repeat (LAT + 1) cycle("drain4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
